fetch_stage: RTL and testbench

- Instruction-fetch stage of the LEGv8 pipeline; sits directly downstream of sl2.
- Owns the PC register and issues requests to instruction memory over a req/ready handshake.
- Computes the branch target from the sl2 output (`branch_off`) plus the branch instruction's PC, and redirects on `pcsrc`.
- Drives the IF/ID pipeline register, with stall and a one-entry skid buffer.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_stage_adder.sv | 12 +
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        HOLD
    } fetch_state_t;

    localparam int unsigned PC_INC       = 4;
    localparam logic [31:0] IF_ID_BUBBLE = 32'h0;

endpackage

// File: rtl/fetch_stage_adder.sv
// Plain modulo-2^W adder, used for PC+4 and for the branch target.
module fetch_stage_adder #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = a + b;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch stage: PC register, imem req/ready handshake, branch redirect,
// and the IF/ID pipeline register with a one-entry skid buffer.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned  N        = 64,
    parameter logic [N-1:0] RESET_PC = {N{1'b0}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] branch_off,
    input  logic [N-1:0] branch_base,
    input  logic         pcsrc,
    input  logic         stall,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic [31:0]  imem_rdata,
    output logic         if_id_valid,
    output logic [N-1:0] if_id_pc,
    output logic [31:0]  if_id_instr
);

    fetch_state_t state_q, state_d;
    logic [N-1:0] pc_q, pc_d, pc_next, target;
    logic         redir_pend_q, redir_pend_d;
    logic [N-1:0] redir_tgt_q, redir_tgt_d;
    logic [N-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]  skid_instr_q, skid_instr_d;
    logic         if_id_valid_q, if_id_valid_d;
    logic [N-1:0] if_id_pc_q, if_id_pc_d;
    logic [31:0]  if_id_instr_q, if_id_instr_d;

    fetch_stage_adder #(.W(N)) u_pc_inc (
        .a (pc_q),
        .b (N'(PC_INC)),
        .y (pc_next)
    );

    fetch_stage_adder #(.W(N)) u_br_tgt (
        .a (branch_base),
        .b (branch_off),
        .y (target)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redir_pend_d  = redir_pend_q;
        redir_tgt_d   = redir_tgt_q;
        skid_pc_d     = skid_pc_q;
        skid_instr_d  = skid_instr_q;
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        imem_req      = 1'b0;

        unique case (state_q)
            BOOT: begin
                state_d = REQ;
                if (pcsrc) pc_d = target;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if (pcsrc || redir_pend_q) begin
                        // Wrong-path word: drop it; a live pcsrc beats the pending one.
                        pc_d         = pcsrc ? target : redir_tgt_q;
                        redir_pend_d = 1'b0;
                    end else if (!stall) begin
                        if_id_valid_d = 1'b1;
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = imem_rdata;
                        pc_d          = pc_next;
                    end else begin
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_rdata;
                        pc_d         = pc_next;
                        state_d      = HOLD;
                    end
                end else if (pcsrc) begin
                    // Address must stay stable until the transfer; remember the redirect.
                    redir_pend_d = 1'b1;
                    redir_tgt_d  = target;
                end
            end
            HOLD: begin
                if (pcsrc) begin
                    pc_d    = target;
                    state_d = REQ;
                end else if (!stall) begin
                    if_id_valid_d = 1'b1;
                    if_id_pc_d    = skid_pc_q;
                    if_id_instr_d = skid_instr_q;
                    state_d       = REQ;
                end
            end
            default: state_d = BOOT;
        endcase

        if (pcsrc) if_id_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            redir_pend_q  <= 1'b0;
            redir_tgt_q   <= '0;
            skid_pc_q     <= '0;
            skid_instr_q  <= '0;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= IF_ID_BUBBLE;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redir_pend_q  <= redir_pend_d;
            redir_tgt_q   <= redir_tgt_d;
            skid_pc_q     <= skid_pc_d;
            skid_instr_q  <= skid_instr_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_valid = if_id_valid_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected IF/ID loads into a
// queue, a negedge monitor pops them whenever a new instruction appears.
module tb_fetch_stage;

    localparam int unsigned N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] branch_off;
    logic [N-1:0] branch_base;
    logic         pcsrc;
    logic         stall;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ready;
    logic [31:0]  imem_rdata;
    logic         if_id_valid;
    logic [N-1:0] if_id_pc;
    logic [31:0]  if_id_instr;

    int n_cmp = 0;
    int n_err = 0;

    logic [N-1:0] exp_q[$];
    logic         prev_v = 1'b0;
    logic [N-1:0] prev_pc = '0;

    fetch_stage #(.N(N), .RESET_PC(64'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .branch_off  (branch_off),
        .branch_base (branch_base),
        .pcsrc       (pcsrc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [N-1:0] a);
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    // Memory model: word content is a function of the address.
    assign imem_rdata = instr_of(imem_addr);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [N-1:0] base, input logic [N-1:0] off);
        branch_base = base;
        branch_off  = off;
        pcsrc       = 1'b1;
    endtask

    task automatic unredirect();
        pcsrc       = 1'b0;
        branch_base = '0;
        branch_off  = '0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            prev_v <= 1'b0;
        end else begin
            if (if_id_valid && (!prev_v || if_id_pc != prev_pc)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL ifid_unexpected: got pc %h, expected no new instruction",
                             if_id_pc);
                end else begin
                    logic [N-1:0] e;
                    e = exp_q.pop_front();
                    if (if_id_pc !== e || if_id_instr !== instr_of(e)) begin
                        n_err++;
                        $display("FAIL ifid_load: got pc %h instr %h expected pc %h instr %h",
                                 if_id_pc, if_id_instr, e, instr_of(e));
                    end
                end
            end
            prev_v  <= if_id_valid;
            prev_pc <= if_id_pc;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b0;
        branch_off  = '0;
        branch_base = '0;
        pcsrc       = 1'b0;
        stall       = 1'b0;
        imem_ready  = 1'b1;
        #3;
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_addr", imem_addr, 64'd0);
        chk("rst_valid", {63'd0, if_id_valid}, 64'd0);
        chk("rst_pc", if_id_pc, 64'd0);
        chk("rst_instr", {32'd0, if_id_instr}, 64'd0);
        tick();
        reset = 1'b1;
        chk("boot_req", {63'd0, imem_req}, 64'd0);

        // Streaming: first load after the 2nd edge.
        tick();
        chk("e1_req", {63'd0, imem_req}, 64'd1);
        chk("e1_addr", imem_addr, 64'd0);
        chk("e1_valid", {63'd0, if_id_valid}, 64'd0);
        exp_q.push_back(64'h0);
        tick();
        chk("e2_addr", imem_addr, 64'h4);
        chk("e2_valid", {63'd0, if_id_valid}, 64'd1);
        exp_q.push_back(64'h4);
        tick();
        exp_q.push_back(64'h8);
        tick();
        exp_q.push_back(64'hC);
        tick();
        chk("e5_addr", imem_addr, 64'h10);

        // Memory wait at 0x10.
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_req", {63'd0, imem_req}, 64'd1);
            chk("wait_addr", imem_addr, 64'h10);
            chk("wait_ifid_pc", if_id_pc, 64'hC);
        end
        imem_ready = 1'b1;
        exp_q.push_back(64'h10);
        tick();
        chk("after_wait_addr", imem_addr, 64'h14);

        // Redirect with ready high: fetched word dropped.
        redirect(64'h100, 64'h40);
        tick();
        chk("br_addr", imem_addr, 64'h140);
        chk("br_flush", {63'd0, if_id_valid}, 64'd0);
        unredirect();
        exp_q.push_back(64'h140);
        tick();
        chk("br_next_addr", imem_addr, 64'h144);

        // Go to 0x20, then redirect while the 0x20 request is waiting.
        redirect(64'h10, 64'h10);
        tick();
        chk("to20_addr", imem_addr, 64'h20);
        unredirect();
        imem_ready = 1'b0;
        tick();
        chk("w20_addr_a", imem_addr, 64'h20);
        redirect(64'h1C0, 64'h40);
        tick();
        chk("w20_addr_b", imem_addr, 64'h20);
        chk("w20_req_b", {63'd0, imem_req}, 64'd1);
        unredirect();
        tick();
        chk("w20_addr_c", imem_addr, 64'h20);
        imem_ready = 1'b1;
        tick();
        chk("pend_addr", imem_addr, 64'h200);
        chk("pend_valid", {63'd0, if_id_valid}, 64'd0);
        exp_q.push_back(64'h200);
        tick();
        chk("pend_next_addr", imem_addr, 64'h204);

        // Stall across the 0x30 transfer.
        redirect(64'h20, 64'hC);
        tick();
        chk("to2c_addr", imem_addr, 64'h2C);
        unredirect();
        exp_q.push_back(64'h2C);
        tick();
        chk("at30_addr", imem_addr, 64'h30);
        stall = 1'b1;
        tick();
        chk("hold_req_a", {63'd0, imem_req}, 64'd0);
        chk("hold_addr", imem_addr, 64'h34);
        chk("hold_pc_a", if_id_pc, 64'h2C);
        chk("hold_valid_a", {63'd0, if_id_valid}, 64'd1);
        tick();
        chk("hold_req_b", {63'd0, imem_req}, 64'd0);
        chk("hold_pc_b", if_id_pc, 64'h2C);
        stall = 1'b0;
        exp_q.push_back(64'h30);
        tick();
        chk("unhold_req", {63'd0, imem_req}, 64'd1);
        chk("unhold_addr", imem_addr, 64'h34);
        exp_q.push_back(64'h34);
        tick();
        chk("unhold_next", imem_addr, 64'h38);

        // Address wrap-around.
        redirect(64'hFFFF_FFFF_FFFF_FFF0, 64'hC);
        tick();
        chk("to_top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        unredirect();
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("wrap_addr", imem_addr, 64'h0);
        redirect(64'hFFFF_FFFF_FFFF_FFF0, 64'h20);
        tick();
        chk("tgt_wrap_addr", imem_addr, 64'h10);
        unredirect();
        exp_q.push_back(64'h10);
        tick();
        chk("tgt_wrap_next", imem_addr, 64'h14);
        redirect(64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        tick();
        chk("ones_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        unredirect();
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("ones_wrap", imem_addr, 64'h3);

        // Reset while a request is outstanding.
        imem_ready = 1'b0;
        tick();
        chk("pre_rst_req", {63'd0, imem_req}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_req", {63'd0, imem_req}, 64'd0);
        chk("mid_rst_addr", imem_addr, 64'd0);
        chk("mid_rst_valid", {63'd0, if_id_valid}, 64'd0);
        chk("mid_rst_pc", if_id_pc, 64'd0);
        chk("mid_rst_instr", {32'd0, if_id_instr}, 64'd0);
        tick();
        reset      = 1'b1;
        imem_ready = 1'b1;
        tick();
        chk("rb_addr", imem_addr, 64'h0);
        chk("rb_valid", {63'd0, if_id_valid}, 64'd0);
        exp_q.push_back(64'h0);
        tick();
        chk("rb_next_addr", imem_addr, 64'h4);
        imem_ready = 1'b0;
        tick();
        tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
